// File: rtl/pcie_rdreq_pkg.sv
// Shared types for the ingress read-request scheduler: target action codes,
// register codes, the decoded rd_tdest layout and the scheduler FSM states.
package pcie_rdreq_pkg;

  typedef enum logic [1:0] {
    ACT_TX  = 2'b00,
    ACT_RX  = 2'b01,
    ACT_GLB = 2'b10,
    ACT_RSV = 2'b11
  } act_e;

  // Per-channel TX/RX register map
  localparam logic [2:0] TRX_REG_CTRL = 3'b000;
  localparam logic [2:0] TRX_REG_STAT = 3'b001;
  localparam logic [2:0] TRX_REG_CFG0 = 3'b010;
  localparam logic [2:0] TRX_REG_CFG1 = 3'b011;
  localparam logic [2:0] TRX_REG_CNT0 = 3'b100;
  localparam logic [2:0] TRX_REG_CNT1 = 3'b101;

  // Global register map
  localparam logic [2:0] GLB_REG_ID   = 3'b000;
  localparam logic [2:0] GLB_REG_CTRL = 3'b001;
  localparam logic [2:0] GLB_REG_STAT = 3'b010;
  localparam logic [2:0] GLB_REG_IRQ  = 3'b011;

  typedef struct packed {
    logic [2:0] reg_sel;
    act_e       act;
    logic [3:0] chn;
  } rd_tdest_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CPL   = 2'd3
  } state_e;

  function automatic logic dest_legal(input rd_tdest_t d, input int chn_num);
    return (d.act != ACT_RSV) && (int'(d.chn) < chn_num);
  endfunction

endpackage

// File: rtl/ingress_rdreq_sched_if.sv
// Request-in / completion-out bus of the read-request scheduler.
// master = parser/egress side, slave = scheduler.
interface ingress_rdreq_sched_if #(
  parameter int META_W = 24
);
  logic              rd_req;
  logic [9:0]        rd_tdest;
  logic [META_W-1:0] rd_meta;
  logic              rd_ovf;
  logic              cpl_valid;
  logic              cpl_rdy;
  logic [31:0]       cpl_data;
  logic [META_W-1:0] cpl_meta;
  logic              cpl_err;

  modport master (
    output rd_req, rd_tdest, rd_meta, cpl_rdy,
    input  rd_ovf, cpl_valid, cpl_data, cpl_meta, cpl_err
  );

  modport slave (
    input  rd_req, rd_tdest, rd_meta, cpl_rdy,
    output rd_ovf, cpl_valid, cpl_data, cpl_meta, cpl_err
  );
endinterface

// File: rtl/ingress_rdreq_sched_fifo.sv
// rdreq_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers.
module rdreq_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage carries data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ingress_rdreq_sched.sv
// Read-request scheduler: queues parsed reads, issues one register read at a time,
// waits for ack or timeout, returns one completion beat. Optional stats: RDREQ_SCHED_STAT_EN.
module ingress_rdreq_sched
  import pcie_rdreq_pkg::*;
#(
  parameter int CHN_NUM     = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int META_W      = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  ingress_rdreq_sched_if.slave    bus,
  output logic [2:0]              tgt_reg,
  output logic [CHN_NUM-1:0]      tx_rd_req,
  output logic [CHN_NUM-1:0]      rx_rd_req,
  output logic                    glb_rd_req,
  input  logic [CHN_NUM-1:0]      tx_rd_ack,
  input  logic [CHN_NUM-1:0]      rx_rd_ack,
  input  logic                    glb_rd_ack,
  input  logic [CHN_NUM*32-1:0]   tx_rd_data,
  input  logic [CHN_NUM*32-1:0]   rx_rd_data,
  input  logic [31:0]             glb_rd_data
`ifdef RDREQ_SCHED_STAT_EN
  ,
  input  logic                    stat_clr,
  output logic [15:0]             stat_rd_cnt,
  output logic [15:0]             stat_to_cnt,
  output logic [15:0]             stat_ovf_cnt
`endif
);
  localparam int          FW     = 9 + META_W;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  state_e            state, state_nxt;
  rd_tdest_t         wk_dest;
  rd_tdest_t         head_dest;
  logic [META_W-1:0] head_meta;
  logic [FW-1:0]     fifo_dout;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              head_ok, load_head, cap_ack, cap_to;
  logic              sel_ack, to_hit, issue;
  logic [31:0]       sel_data;
  logic [15:0]       to_cnt;
  logic [31:0]       cpl_data_q;
  logic [META_W-1:0] cpl_meta_q;
  logic              cpl_err_q;
  logic              rd_ovf_q;

  // Full is sampled before this cycle's pop, so a full queue drops even if IDLE pops
  assign fifo_push = bus.rd_req && !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  rdreq_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({bus.rd_tdest[8:0], bus.rd_meta}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_dest = rd_tdest_t'(fifo_dout[FW-1:META_W]);
  assign head_meta = fifo_dout[META_W-1:0];
  assign head_ok   = dest_legal(head_dest, CHN_NUM);
  assign issue     = (state == ST_ISSUE);
  assign to_hit    = ((to_cnt + 16'd1) == TO_LIM);

  // Target strobe decode and ack/data select; only the working target is observed
  always_comb begin
    tx_rd_req  = '0;
    rx_rd_req  = '0;
    glb_rd_req = 1'b0;
    sel_ack    = 1'b0;
    sel_data   = '0;
    for (int n = 0; n < CHN_NUM; n++) begin
      if (wk_dest.chn == 4'(n)) begin
        if (wk_dest.act == ACT_TX) begin
          tx_rd_req[n] = issue;
          sel_ack      = tx_rd_ack[n];
          sel_data     = tx_rd_data[n*32 +: 32];
        end else if (wk_dest.act == ACT_RX) begin
          rx_rd_req[n] = issue;
          sel_ack      = rx_rd_ack[n];
          sel_data     = rx_rd_data[n*32 +: 32];
        end
      end
    end
    if (wk_dest.act == ACT_GLB) begin
      glb_rd_req = issue;
      sel_ack    = glb_rd_ack;
      sel_data   = glb_rd_data;
    end
    tgt_reg = issue ? wk_dest.reg_sel : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    cap_ack   = 1'b0;
    cap_to    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_head = 1'b1;
          state_nxt = head_ok ? ST_ISSUE : ST_CPL;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // An ack on the timeout cycle still wins
        if (sel_ack) begin
          cap_ack   = 1'b1;
          state_nxt = ST_CPL;
        end else if (to_hit) begin
          cap_to    = 1'b1;
          state_nxt = ST_CPL;
        end
      end
      ST_CPL: if (bus.cpl_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Working request and completion beat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wk_dest    <= '0;
      to_cnt     <= '0;
      cpl_data_q <= '0;
      cpl_meta_q <= '0;
      cpl_err_q  <= 1'b0;
      rd_ovf_q   <= 1'b0;
    end else begin
      rd_ovf_q <= bus.rd_req && fifo_full;
      if (load_head) begin
        wk_dest    <= head_dest;
        cpl_meta_q <= head_meta;
        cpl_data_q <= '0;
        cpl_err_q  <= !head_ok;
      end
      if (issue) to_cnt <= '0;
      if (cap_ack) begin
        cpl_data_q <= sel_data;
        cpl_err_q  <= 1'b0;
      end else if (cap_to) begin
        cpl_data_q <= '0;
        cpl_err_q  <= 1'b1;
      end else if (state == ST_WAIT) begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

  assign bus.rd_ovf    = rd_ovf_q;
  assign bus.cpl_valid = (state == ST_CPL);
  assign bus.cpl_data  = cpl_data_q;
  assign bus.cpl_meta  = cpl_meta_q;
  assign bus.cpl_err   = cpl_err_q;

`ifdef RDREQ_SCHED_STAT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt  <= '0;
      stat_to_cnt  <= '0;
      stat_ovf_cnt <= '0;
    end else if (stat_clr) begin
      stat_rd_cnt  <= '0;
      stat_to_cnt  <= '0;
      stat_ovf_cnt <= '0;
    end else begin
      if (bus.cpl_valid && bus.cpl_rdy) stat_rd_cnt  <= sat_inc(stat_rd_cnt);
      if (cap_to)                       stat_to_cnt  <= sat_inc(stat_to_cnt);
      if (rd_ovf_q)                     stat_ovf_cnt <= sat_inc(stat_ovf_cnt);
    end
  end
`endif
endmodule

// File: doc/ingress_rdreq_sched.md
Name: ingress_rdreq_sched

Overview:
- Sits between ingress_parse_rdreq and the per-channel TX/RX action modules and the global register block.
- Buffers decoded read requests together with their completion metadata.
- Issues one register read at a time to the addressed target, waits for the ack or a timeout, then presents one completion beat to the egress completion builder.
- Upstream has no backpressure (rdreq_rdy is tied high), so this block absorbs bursts and flags overflow.

Parameters:
- CHN_NUM, 12, number of TX/RX channel pairs; legal 1..16.
- FIFO_DEPTH, 4, request queue depth; power of two, >= 2.
- TIMEOUT_CYC, 255, cycles spent in WAIT before an error completion; legal 1..65535.
- META_W, 24, width of completion metadata (requester ID 16 + tag 8).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  single-cycle request strobe from the parser.
- rd_tdest  in  10  {unused[9], register[8:6], action[5:4], channel[3:0]}; action 00=TX, 01=RX, 10=global.
- rd_meta  in  META_W  completion metadata, qualified by rd_req.
- rd_ovf  out  1  one-cycle pulse when rd_req arrives while the queue is full.
- tgt_reg  out  3  register select, valid while any target strobe is high.
- tx_rd_req  out  CHN_NUM  one-hot TX channel read strobe.
- rx_rd_req  out  CHN_NUM  one-hot RX channel read strobe.
- glb_rd_req  out  1  global register read strobe.
- tx_rd_ack  in  CHN_NUM  TX read ack, per channel.
- rx_rd_ack  in  CHN_NUM  RX read ack, per channel.
- glb_rd_ack  in  1  global read ack.
- tx_rd_data  in  CHN_NUM*32  TX read data; channel n occupies [n*32+:32].
- rx_rd_data  in  CHN_NUM*32  RX read data, same packing.
- glb_rd_data  in  32  global read data.
- cpl_valid  out  1  completion beat valid.
- cpl_rdy  in  1  egress ready.
- cpl_data  out  32  completion payload.
- cpl_meta  out  META_W  metadata of the completed request.
- cpl_err  out  1  1 = timeout or illegal destination; cpl_data is 0 in that case.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, timeout counter 0.
- Enqueue:
  - rd_req && !full pushes {rd_tdest, rd_meta} at the clock edge.
  - rd_req && full drops the request and pulses rd_ovf for one cycle.
  - A push and a pop in the same cycle are both legal; the full flag is evaluated before the pop.
- FSM states: IDLE, ISSUE, WAIT, CPL.
- IDLE:
  - If the FIFO is not empty, pop the head into the working registers and decode it.
  - Legal destination (action != 11 and channel < CHN_NUM) -> ISSUE.
  - Illegal destination -> CPL with cpl_err=1 and cpl_data=0.
- ISSUE:
  - Drive exactly one target strobe high for exactly one cycle, with tgt_reg = register field.
  - Clear the timeout counter; go to WAIT.
  - Minimum latency from rd_req to cpl_valid is 4 cycles with an ack on the first WAIT cycle.
- WAIT:
  - Only the ack of the selected target is sampled; acks from any other target are ignored.
  - On the selected ack, capture the matching 32-bit data slice and go to CPL with cpl_err=0.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYC, go to CPL with cpl_err=1 and cpl_data=0.
  - An ack in the same cycle the counter reaches TIMEOUT_CYC takes priority: capture the data, no error.
- CPL:
  - cpl_valid=1; cpl_data, cpl_meta and cpl_err are held stable until cpl_valid && cpl_rdy.
  - After the handshake, return to IDLE. There is no IDLE bypass, so at most one completion per 2 cycles.
- Late ack: an ack arriving after a timeout is ignored. Strict ordering holds, with one request outstanding at a time.
- Reset mid-operation: the FIFO and the in-flight request are discarded, no completion is emitted, and outputs go to 0 asynchronously.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and the remaining bits are equal.
  - empty = pointers equal.

Optional Feature:
- Macro: RDREQ_SCHED_STAT_EN.
- When defined, three saturating 16-bit counters are added, plus input stat_clr (1 bit, synchronous clear, takes priority over increments):
  - stat_rd_cnt counts completed requests.
  - stat_to_cnt counts timeouts.
  - stat_ovf_cnt counts rd_ovf pulses.
- When not defined, these ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Package pcie_rdreq_pkg holds:
  - the action enum (ACT_TX=2'b00, ACT_RX=2'b01, ACT_GLB=2'b10);
  - the register codes for TX/RX (000..101) and global (000..011);
  - the rd_tdest packed struct {reg, act, chn};
  - the state enum.
- One sub-module, rdreq_fifo: a parameterised synchronous FIFO with push/pop/full/empty.

Test Plan:
- Reset, then rd_req with tdest={3'b010,2'b00,4'd3}, tx_rd_ack[3] two cycles after the strobe, data 32'hA5A5_0003 -> tx_rd_req==12'h008 for one cycle, tgt_reg=3'b010, then cpl_valid with cpl_data=32'hA5A5_0003, cpl_err=0, cpl_meta echoed.
- Global read {3'b011,2'b10,4'd0}, no ack ever -> glb_rd_req pulses; after 255 WAIT cycles cpl_valid with cpl_err=1, cpl_data=0; a later glb_rd_ack is ignored.
- Illegal action 2'b11, and channel 13 with CHN_NUM=12 -> no target strobe; cpl_err=1 within 2 cycles of the pop.
- Six back-to-back rd_req while cpl_rdy is held low, FIFO_DEPTH=4 -> one request held in CPL, four queued, rd_ovf pulses once; releasing cpl_rdy yields 5 completions in order.
- rx_rd_ack[5] asserted while channel 2 is in WAIT, then rx_rd_ack[2] -> only the channel 2 data is captured.
- Assert rst during WAIT -> all outputs are 0 immediately; after release, a new request completes normally.
